// File: rtl/mem_bus_pkg.sv
// Shared data-bus definitions: transfer size codes, responder FSM states and
// the request record latched at the sampling edge.
package mem_bus_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: write enables and shifted store data,
// right-justified zero-extended load data, and alignment check.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] rsh;

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    rdata    = 32'h0;
    wdata_sh = wdata << {lane, 3'b000};
    rsh      = rword >> {lane, 3'b000};
    case (size)
      SIZE_WORD: begin
        misalign = (lane != 2'd0);
        be       = 4'b1111;
        rdata    = rsh;
      end
      SIZE_HALF: begin
        misalign = lane[0];
        be       = 4'b0011 << lane;
        rdata    = {16'h0, rsh[15:0]};
      end
      SIZE_BYTE: begin
        be    = 4'b0001 << lane;
        rdata = {24'h0, rsh[7:0]};
      end
      default: ;
    endcase
    // Illegal size leaves be at zero; misaligned accesses must not write either.
    if (misalign) be = 4'b0000;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus memory slave: samples a request in IDLE, waits WAIT_CYCLES, then
// commits the access and acknowledges for one cycle with ACKD_n low.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  tri   [31:0] DDT,
  output logic        ACKD_n,
  output logic        ERR
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > WAIT_MAX) ? 4'(WAIT_MAX) : 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  mem_req_t    req_q, req_d, cur;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      off;
  logic             in_range, acc_err, commit, drv_en;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata_sh, rdata_al;
  logic             misalign;

  // With zero wait states the commit edge is the sampling edge, so the live
  // bus is used in IDLE and the latched copy afterwards.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) cur = '{wr: WRITE, size: SIZE, addr: DAD, data: DDT};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (MREQ) begin
        req_d   = cur;
        cnt_d   = WAIT_INIT;
        state_d = (WAIT_INIT == 4'd0) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign off      = cur.addr - BASE_ADDR;
  assign in_range = (cur.addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  mem_lane_align u_align (
    .size     (cur.size),
    .lane     (cur.addr[1:0]),
    .wdata    (cur.data),
    .rword    (mem_q[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_al),
    .misalign (misalign)
  );

  assign acc_err = !in_range || misalign || (cur.size == 2'b11);
  // Held-off during reset so a request seen under reset never touches the RAM.
  assign commit  = !rst && (state_d == ACK) && (state_q != ACK);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      rdata_d = acc_err ? 32'h0 : rdata_al;
      err_d   = err_q | acc_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur.wr && !acc_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  always_comb begin
    ACKD_n = (state_q != ACK);
    drv_en = (state_q == ACK) && !req_q.wr;
    ERR    = err_q;
  end

  assign DDT = drv_en ? rdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3)
// checked every cycle against a byte-addressed reference model.
module tb_data_mem_responder;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst, mreq, write, drv_en;
  logic [2:0][1:0]   size;
  logic [2:0][31:0]  dad, drv_dat;
  wire  [2:0][31:0]  ddt_obs;
  wire  [2:0]        ack_n, err;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      tri1 [31:0] ddt;
      assign ddt = drv_en[k] ? drv_dat[k] : 32'hzzzz_zzzz;
      assign ddt_obs[k] = ddt;
      data_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES((k == 0) ? 1 : (k == 1) ? 0 : 3)
      ) dut (
        .clk(clk), .rst(rst[k]), .MREQ(mreq[k]), .WRITE(write[k]), .SIZE(size[k]),
        .DAD(dad[k]), .DDT(ddt), .ACKD_n(ack_n[k]), .ERR(err[k])
      );
    end
  endgenerate

  typedef struct {
    int          ack_cyc;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  int          nchk = 0, nerr = 0, cyc = 0, sel = 0;
  bit          run = 1'b0;
  bit          merr [3];
  exp_t        q [$];
  int          ack_log [$];
  logic [31:0] last_rd;
  logic [7:0]  mb [3][64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Memory as a flat byte array: an access touches nb consecutive bytes.
  task automatic model(input int k, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output bit e, output logic [31:0] r);
    logic [31:0] off;
    int nb;
    off = a - BASE;
    nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    e   = (a < BASE) || (off >= 32'(DEPTH * 4)) || (sz == 2'b11) || ((a % 32'(nb)) != 0);
    r   = 32'h0;
    if (!e)
      for (int i = 0; i < nb; i++)
        if (wr) mb[k][int'(off) + i] = d[8*i +: 8];
        else    r[8*i +: 8] = mb[k][int'(off) + i];
  endtask

  // Called 1 time unit after a rising edge while the selected DUT is idle.
  task automatic req(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input bit junk);
    exp_t e;
    int k;
    k = sel;
    model(k, wr, sz, a, d, e.err, e.data);
    e.rd = !wr;
    e.ack_cyc = cyc + 1 + wc_of(k);
    q.push_back(e);
    mreq[k] = 1'b1; write[k] = wr; size[k] = sz; dad[k] = a; drv_dat[k] = d; drv_en[k] = wr;
    @(posedge clk); #1;
    drv_en[k] = 1'b0; drv_dat[k] = $urandom;
    if (junk) begin
      write[k] = 1'($urandom); size[k] = 2'($urandom); dad[k] = $urandom;
    end else mreq[k] = 1'b0;
    repeat (wc_of(k) + 1) @(posedge clk);
    #1 mreq[k] = 1'b0;
  endtask

  task automatic rnd_req();
    logic [31:0] a;
    logic [1:0]  sz;
    int pick;
    sz   = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    pick = $urandom_range(0, 9);
    if (pick == 0)      a = BASE + 32'(DEPTH * 4) + $urandom_range(0, 31);
    else if (pick == 1) a = BASE - 32'($urandom_range(1, 16));
    else begin
      a = BASE + $urandom_range(0, DEPTH * 4 - 1);
      if ($urandom_range(0, 3) != 0)
        a = (sz == 2'b00) ? {a[31:2], 2'b00} : (sz == 2'b01) ? {a[31:1], 1'b0} : a;
    end
    req(1'($urandom), sz, a, $urandom, 1'($urandom));
  endtask

  task automatic init_words();
    for (int w = 0; w < DEPTH; w++) req(1'b1, 2'b00, BASE + 32'(4 * w), $urandom, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ea;
    int   k;
    if (run) begin
      k  = sel;
      ea = 1'b0;
      e  = '{ack_cyc: 0, rd: 1'b0, data: 32'h0, err: 1'b0};
      while (q.size() > 0 && q[0].ack_cyc < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].ack_cyc == cyc) begin
        ea = 1'b1;
        e  = q[0];
        if (e.err) merr[k] = 1'b1;
      end
      chk("ackd_n", 32'(ack_n[k]), 32'(!ea));
      chk("err", 32'(err[k]), 32'(merr[k]));
      if (!drv_en[k]) chk("ddt", ddt_obs[k], (ea && e.rd) ? e.data : 32'hFFFF_FFFF);
      if (!ack_n[k]) begin
        last_rd = ddt_obs[k];
        ack_log.push_back(cyc);
      end
    end
  end

  initial begin
    rst = '0; mreq = '0; write = '0; size = '0; dad = '0; drv_en = '0; drv_dat = '0;
    #1 rst = '1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ackd_n", 32'(ack_n[k]), 32'd1);
      chk("reset_err", 32'(err[k]), 32'd0);
      chk("reset_ddt_z", ddt_obs[k], 32'hFFFF_FFFF);
    end
    @(posedge clk); #1 rst = '0; run = 1'b1;

    // WAIT_CYCLES=1 instance: directed cases then random traffic
    sel = 0;
    init_words();
    req(1'b1, 2'b00, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    req(1'b0, 2'b00, BASE + 32'h10, 32'h0, 1'b0);
    chk("word_rd", last_rd, 32'hDEAD_BEEF);
    chk("word_err", 32'(err[0]), 32'd0);
    for (int i = 0; i < 4; i++) req(1'b1, 2'b10, BASE + 32'h20 + 32'(i), 32'h11 * 32'(i + 1), 1'b1);
    req(1'b0, 2'b00, BASE + 32'h20, 32'h0, 1'b0);
    chk("bytes_word_rd", last_rd, 32'h4433_2211);
    req(1'b0, 2'b01, BASE + 32'h22, 32'h0, 1'b0);
    chk("half_rd", last_rd, 32'h0000_4433);
    req(1'b1, 2'b01, BASE + 32'h21, 32'h0000_FFFF, 1'b0);
    chk("misalign_err", 32'(err[0]), 32'd1);
    req(1'b0, 2'b00, BASE + 32'h20, 32'h0, 1'b0);
    chk("misalign_no_wr", last_rd, 32'h4433_2211);
    req(1'b0, 2'b00, BASE + 32'(DEPTH * 4), 32'h0, 1'b0);
    chk("oor_rd", last_rd, 32'h0);
    req(1'b0, 2'b11, BASE + 32'h10, 32'h0, 1'b0);
    chk("size11_rd", last_rd, 32'h0);
    req(1'b0, 2'b00, BASE - 32'd4, 32'h0, 1'b0);
    chk("below_base_rd", last_rd, 32'h0);
    chk("err_sticky", 32'(err[0]), 32'd1);
    repeat (60) rnd_req();

    // WAIT_CYCLES=0 instance: back-to-back reads with MREQ held high
    sel = 1;
    init_words();
    ack_log.delete();
    for (int i = 0; i < 4; i++) req(1'b0, 2'b00, BASE + 32'(4 * i), 32'h0, 1'b1);
    chk("b2b_ack_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) chk("b2b_spacing", 32'(ack_log[3] - ack_log[0]), 32'd6);
    repeat (60) rnd_req();

    // WAIT_CYCLES=3 instance: reset during WAIT of a write drops it
    sel = 2;
    init_words();
    req(1'b1, 2'b00, BASE + 32'h10, 32'hCAFE_F00D, 1'b0);
    mreq[2] = 1'b1; write[2] = 1'b1; size[2] = 2'b00; dad[2] = BASE + 32'h10;
    drv_dat[2] = 32'h1234_5678; drv_en[2] = 1'b1;
    @(posedge clk); #1 mreq[2] = 1'b0; drv_en[2] = 1'b0;
    @(posedge clk); #1 rst[2] = 1'b1;
    #2 rst[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rst_err", 32'(err[2]), 32'd0);
    req(1'b0, 2'b00, BASE + 32'h10, 32'h0, 1'b0);
    chk("rst_keeps_word", last_rd, 32'hCAFE_F00D);
    repeat (60) rnd_req();

    repeat (3) @(posedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
